// File: rtl/grid_frame_sequencer.sv
// Frame sequencer: loads packets into a one-entry grid input buffer, waits for
// the grid to drain, issues settle-spaced ticks, counts spikes, traps errors.
module grid_frame_sequencer #(
    parameter int PACKET_WIDTH   = 30,
    parameter int DRAIN_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [15:0]             num_packets,
    input  logic [7:0]              num_ticks,
    input  logic                    src_valid,
    input  logic [PACKET_WIDTH-1:0] src_packet,
    output logic                    src_ready,
    output logic [PACKET_WIDTH-1:0] grid_packet_in,
    output logic                    grid_input_buffer_empty,
    input  logic                    grid_ren,
    output logic                    grid_tick,
    input  logic                    grid_drained,
    input  logic                    grid_packet_out_valid,
    input  logic                    grid_token_controller_error,
    input  logic                    grid_scheduler_error,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             spike_count,
    output logic                    error,
    output logic [2:0]              error_code
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_TICK   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT_CYCLES - 1);

    logic [2:0]              state;
    logic [2:0]              state_nx;
    logic [15:0]             num_pkts_q;
    logic [7:0]              num_ticks_q;
    logic [15:0]             pkt_cnt;
    logic [7:0]              tick_cnt;
    logic [DW-1:0]           drain_cnt;
    logic [SW-1:0]           settle_cnt;
    logic [WW-1:0]           wd_cnt;
    logic                    hold_valid;
    logic [PACKET_WIDTH-1:0] hold_data;

    logic start_ok;
    logic load;
    logic drain_done;
    logic settle_done;
    logic wd_hit;
    logic [2:0] err_set;

    assign busy        = (state != S_IDLE) && (state != S_ERROR);
    assign frame_done  = (state == S_DONE);
    assign grid_tick   = (state == S_TICK);
    assign error       = |error_code;

    assign grid_packet_in          = hold_data;
    assign grid_input_buffer_empty = ~hold_valid;

    // A consume this cycle frees the entry, so a new load may overlap it.
    assign src_ready = (state == S_LOAD) && (pkt_cnt < num_pkts_q)
                     && (!hold_valid || grid_ren);
    assign load      = src_valid && src_ready;
    assign start_ok  = (state == S_IDLE) && start;

    assign drain_done  = (state == S_DRAIN) && grid_drained
                       && (drain_cnt == DRAIN_LAST);
    assign settle_done = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);
    assign wd_hit      = (state == S_DRAIN) && (wd_cnt == WD_LAST);

    assign err_set = busy ? {wd_hit, grid_scheduler_error,
                             grid_token_controller_error} : 3'b000;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   if (pkt_cnt == num_pkts_q && !hold_valid)
                          state_nx = S_DRAIN;
            S_DRAIN:  if (drain_done)
                          state_nx = (tick_cnt < num_ticks_q) ? S_TICK : S_DONE;
            S_TICK:   state_nx = S_SETTLE;
            S_SETTLE: if (settle_done) state_nx = S_DRAIN;
            S_DONE:   state_nx = S_IDLE;
            S_ERROR:  state_nx = S_ERROR;
            default:  state_nx = S_IDLE;
        endcase
        if (|err_set) state_nx = S_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            num_pkts_q  <= '0;
            num_ticks_q <= '0;
            pkt_cnt     <= '0;
            tick_cnt    <= '0;
            drain_cnt   <= '0;
            settle_cnt  <= '0;
            wd_cnt      <= '0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            spike_count <= '0;
            error_code  <= '0;
        end else begin
            state      <= state_nx;
            error_code <= error_code | err_set;
            hold_valid <= load | (hold_valid & ~grid_ren);

            if (load) begin
                hold_data <= src_packet;
                pkt_cnt   <= pkt_cnt + 16'd1;
            end

            if (state == S_TICK) tick_cnt <= tick_cnt + 8'd1;

            if (state == S_DRAIN && grid_drained && !drain_done)
                drain_cnt <= drain_cnt + 1'b1;
            else
                drain_cnt <= '0;

            if (state == S_SETTLE && !settle_done)
                settle_cnt <= settle_cnt + 1'b1;
            else
                settle_cnt <= '0;

            wd_cnt <= (state == S_DRAIN) ? wd_cnt + 1'b1 : '0;

            if (start_ok) begin
                num_pkts_q  <= num_packets;
                num_ticks_q <= num_ticks;
                pkt_cnt     <= '0;
                tick_cnt    <= '0;
                spike_count <= '0;
            end else if (busy && grid_packet_out_valid
                         && spike_count != 16'hFFFF) begin
                spike_count <= spike_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_grid_frame_sequencer.sv
// Directed bench for grid_frame_sequencer: packet scoreboard, tick timing,
// drain/settle spacing, error trapping, watchdog and spike saturation.
module tb_grid_frame_sequencer;

    localparam int PW = 30;
    localparam int DC = 16;
    localparam int SC = 64;
    localparam int TC = 4096;

    logic          clk;
    logic          reset;
    logic          start;
    logic [15:0]   num_packets;
    logic [7:0]    num_ticks;
    logic          src_valid;
    logic [PW-1:0] src_packet;
    logic          src_ready;
    logic [PW-1:0] grid_packet_in;
    logic          grid_input_buffer_empty;
    logic          grid_ren;
    logic          grid_tick;
    logic          grid_drained;
    logic          grid_packet_out_valid;
    logic          grid_token_controller_error;
    logic          grid_scheduler_error;
    logic          busy;
    logic          frame_done;
    logic [15:0]   spike_count;
    logic          error;
    logic [2:0]    error_code;

    grid_frame_sequencer #(
        .PACKET_WIDTH(PW), .DRAIN_CYCLES(DC),
        .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .num_packets(num_packets), .num_ticks(num_ticks),
        .src_valid(src_valid), .src_packet(src_packet),
        .src_ready(src_ready), .grid_packet_in(grid_packet_in),
        .grid_input_buffer_empty(grid_input_buffer_empty),
        .grid_ren(grid_ren), .grid_tick(grid_tick),
        .grid_drained(grid_drained),
        .grid_packet_out_valid(grid_packet_out_valid),
        .grid_token_controller_error(grid_token_controller_error),
        .grid_scheduler_error(grid_scheduler_error),
        .busy(busy), .frame_done(frame_done),
        .spike_count(spike_count), .error(error),
        .error_code(error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_tick   = 0;
    int n_done   = 0;
    int n_push   = 0;
    int n_pop    = 0;
    int tick_last = 0;
    int tick_prev = 0;
    int done_cyc  = 0;
    logic [PW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: accepted source packets are queued, grid reads pop them.
    task automatic sample();
        logic [PW-1:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (grid_ren && !grid_input_buffer_empty) begin
                n_checks++;
                assert (exp_q.size() > 0) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL pkt_unexpected: observed %0h expected none",
                           grid_packet_in);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pkt_order", 32'(grid_packet_in), 32'(e));
                    n_pop++;
                end
            end
            if (src_valid && src_ready) begin
                exp_q.push_back(src_packet);
                n_push++;
            end
        end
        if (grid_tick === 1'b1) begin
            n_tick++;
            tick_prev = tick_last;
            tick_last = cyc;
        end
        if (frame_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int s, t0, d0, p0;

    initial begin
        reset = 1'b1; start = 1'b1; num_packets = 16'd5; num_ticks = 8'd5;
        src_valid = 1'b1; src_packet = '1; grid_ren = 1'b1;
        grid_drained = 1'b1; grid_packet_out_valid = 1'b1;
        grid_token_controller_error = 1'b1; grid_scheduler_error = 1'b1;
        repeat (3) step();
        #1;
        check("rst_src_ready", 32'(src_ready), 0);
        check("rst_empty", 32'(grid_input_buffer_empty), 1);
        check("rst_tick", 32'(grid_tick), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_spike", 32'(spike_count), 0);
        check("rst_error", 32'(error), 0);
        check("rst_pkt_in", 32'(grid_packet_in), 0);

        reset = 1'b0; start = 1'b0; src_valid = 1'b0; grid_ren = 1'b0;
        grid_token_controller_error = 1'b1; grid_scheduler_error = 1'b1;
        step();
        grid_token_controller_error = 1'b0; grid_scheduler_error = 1'b0;
        grid_packet_out_valid = 1'b0;
        step();
        #1;
        check("idle_err_ignored", 32'(error_code), 0);
        check("idle_spike_ignored", 32'(spike_count), 0);
        check("idle_busy", 32'(busy), 0);

        // 3 packets, 2 ticks, read every other cycle
        num_packets = 16'd3; num_ticks = 8'd2; grid_drained = 1'b1;
        src_valid = 1'b1; src_packet = PW'(32'h0ABC_0000);
        t0 = n_tick; d0 = n_done; p0 = n_pop;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 600 && n_done == d0; j++) begin
            grid_ren = j[0];
            src_packet = PW'(32'h0ABC_0000 + 32'(n_push));
            grid_packet_out_valid = (j >= 2 && j <= 8);
            step();
        end
        src_valid = 1'b0; grid_ren = 1'b0; grid_packet_out_valid = 1'b0;
        #1;
        check("f1_done", 32'(n_done - d0), 1);
        check("f1_ticks", 32'(n_tick - t0), 2);
        check("f1_tick_gap_ok", 32'((tick_last - tick_prev) >= SC + DC + 1), 1);
        check("f1_delivered", 32'(n_pop - p0), 3);
        check("f1_q_empty", 32'(exp_q.size()), 0);
        check("f1_spikes", 32'(spike_count), 7);
        check("f1_idle", 32'(busy), 0);

        // empty frame: start cycle + LOAD + DRAIN_CYCLES + DONE
        num_packets = 16'd0; num_ticks = 8'd0;
        t0 = n_tick; d0 = n_done;
        start = 1'b1; s = cyc;
        step();
        start = 1'b0;
        for (int j = 0; j < 100 && n_done == d0; j++) step();
        check("f2_done", 32'(n_done - d0), 1);
        check("f2_done_latency", 32'(done_cyc - s), DC + 2);
        check("f2_no_tick", 32'(n_tick - t0), 0);
        check("f2_spike_cleared", 32'(spike_count), 0);

        // drained glitch at drain count 15 restarts the run
        num_packets = 16'd0; num_ticks = 8'd1; grid_drained = 1'b0;
        t0 = n_tick; d0 = n_done;
        start = 1'b1; s = cyc;
        step();
        for (int j = 1; j <= 40; j++) begin
            start = 1'b0;
            grid_drained = (j >= 2 && j <= 16) || j >= 18;
            step();
        end
        check("f3_ticks", 32'(n_tick - t0), 1);
        check("f3_tick_cycle", 32'(tick_last - s), 34);
        for (int j = 0; j < 200 && n_done == d0; j++) step();
        check("f3_done", 32'(n_done - d0), 1);

        // continuous reads: consume and load overlap, start while busy ignored
        num_packets = 16'd4; num_ticks = 8'd0; grid_drained = 1'b1;
        src_valid = 1'b1; grid_ren = 1'b1;
        d0 = n_done; p0 = n_pop;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 200 && n_done == d0; j++) begin
            src_packet = PW'(32'h1234_0000 + 32'(n_push));
            start = (j == 3);
            num_packets = (j == 3) ? 16'd9 : 16'd4;
            step();
        end
        start = 1'b0; src_valid = 1'b0; grid_ren = 1'b0;
        check("f4_done", 32'(n_done - d0), 1);
        check("f4_delivered", 32'(n_pop - p0), 4);
        check("f4_q_empty", 32'(exp_q.size()), 0);

        // scheduler error in SETTLE
        num_packets = 16'd0; num_ticks = 8'd3; grid_drained = 1'b1;
        t0 = n_tick; d0 = n_done;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 100 && n_tick == t0; j++) step();
        check("f5_first_tick", 32'(n_tick - t0), 1);
        repeat (3) step();
        grid_scheduler_error = 1'b1;
        step();
        grid_scheduler_error = 1'b0;
        #1;
        check("f5_error", 32'(error), 1);
        check("f5_error_code", 32'(error_code), 32'b010);
        check("f5_busy", 32'(busy), 0);
        check("f5_src_ready", 32'(src_ready), 0);
        for (int j = 0; j < 300; j++) begin
            start = (j == 150);
            step();
        end
        start = 1'b0;
        #1;
        check("f5_no_more_ticks", 32'(n_tick - t0), 1);
        check("f5_no_done", 32'(n_done - d0), 0);
        check("f5_sticky", 32'(error_code), 32'b010);
        check("f5_start_ignored", 32'(busy), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("f5_reset_clears", 32'(error_code), 0);

        // DRAIN watchdog
        num_packets = 16'd0; num_ticks = 8'd1; grid_drained = 1'b0;
        start = 1'b1; s = cyc;
        step();
        start = 1'b0;
        while (cyc < s + TC + 1) step();
        #1;
        check("f6_wd_not_yet", 32'(error), 0);
        step();
        #1;
        check("f6_wd_code", 32'(error_code), 32'b100);
        check("f6_wd_busy", 32'(busy), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // reset mid-frame discards the held packet
        num_packets = 16'd2; num_ticks = 8'd1; grid_drained = 1'b1;
        src_valid = 1'b1; grid_ren = 1'b0; src_packet = PW'(32'h0055_AA00);
        t0 = n_tick;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #1;
        check("f7_held", 32'(grid_input_buffer_empty), 0);
        check("f7_busy", 32'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0; src_valid = 1'b0;
        #1;
        check("f7_empty", 32'(grid_input_buffer_empty), 1);
        check("f7_pkt_in", 32'(grid_packet_in), 0);
        check("f7_busy_after", 32'(busy), 0);
        repeat (100) step();
        check("f7_no_tick", 32'(n_tick - t0), 0);

        // spike counter saturation
        num_packets = 16'd1; num_ticks = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        grid_packet_out_valid = 1'b1;
        repeat (65534) step();
        #1;
        check("f8_spike_fffe", 32'(spike_count), 32'hFFFE);
        step();
        #1;
        check("f8_spike_ffff", 32'(spike_count), 32'hFFFF);
        repeat (70000 - 65535) step();
        grid_packet_out_valid = 1'b0;
        #1;
        check("f8_spike_sat", 32'(spike_count), 32'hFFFF);
        check("f8_still_busy", 32'(busy), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
